fanout_fork_ctrl: RTL and testbench

Sequential fork controller for one producer stream broadcast to up to NUM_OUT consumer streams in the onyx stream fabric. It replaces purely combinational all-ready gating with a registered one-token buffer and per-consumer "sent" tracking, so enabled consumers can each take the token in different cycles. The producer is released only after every consumer selected for that token has taken it. It sits between a primitive's output port and its fanout destinations; configuration comes from the tile config registers.

---
 rtl/fanout_pkg.sv | 14 +
 rtl/fanout_lane.sv | 38 +++
 rtl/fanout_fork_ctrl.sv | 106 ++++++++++
 tb/tb_fanout_fork_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fanout_pkg.sv
// Shared types and defaults for the stream fanout fork controller.
package fanout_pkg;

    localparam int FANOUT_NUM_OUT_DEFAULT = 7;
    localparam int FANOUT_DW_DEFAULT      = 17;

    typedef logic [FANOUT_NUM_OUT_DEFAULT-1:0] fanout_mask_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } fanout_state_t;

endpackage

// File: rtl/fanout_lane.sv
// One consumer lane of the fork: tracks whether this lane has already taken
// the buffered token and contributes its term to the token-complete AND.
module fanout_lane (
    input  logic clk,
    input  logic flush,
    input  logic buf_valid_i,
    input  logic tok_mask_i,
    input  logic out_ready_i,
    input  logic clear_i,
    output logic out_valid_o,
    output logic done_term_o
);

    logic sent_q;
    logic sent_d;
    logic take;

    assign out_valid_o = buf_valid_i & tok_mask_i & ~sent_q;
    assign take        = out_valid_o & out_ready_i;
    assign done_term_o = ~tok_mask_i | sent_q | take;

    // A new token or a completed token both start the lane over.
    always_comb begin
        sent_d = sent_q | take;
        if (clear_i) begin
            sent_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            sent_q <= 1'b0;
        end else begin
            sent_q <= sent_d;
        end
    end

endmodule

// File: rtl/fanout_fork_ctrl.sv
// Registered one-token fork: broadcasts a producer word to the selected
// consumers and releases the producer once every selected lane has taken it.
module fanout_fork_ctrl
    import fanout_pkg::*;
#(
    parameter int NUM_OUT    = FANOUT_NUM_OUT_DEFAULT,
    parameter int DATA_WIDTH = FANOUT_DW_DEFAULT
) (
    input  logic                          clk,
    input  logic                          flush,
    input  logic [NUM_OUT-1:0]            cfg_en,
    input  logic [NUM_OUT-1:0]            cfg_sel,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]            out_valid,
    input  logic [NUM_OUT-1:0]            out_ready,
    output logic [15:0]                   tok_count
);

    fanout_state_t           state_q;
    fanout_state_t           state_d;
    logic [DATA_WIDTH-1:0]   buf_data_q;
    logic [DATA_WIDTH-1:0]   buf_data_d;
    logic [NUM_OUT-1:0]      tok_mask_q;
    logic [NUM_OUT-1:0]      tok_mask_d;
    logic [15:0]             tok_count_q;
    logic [15:0]             tok_count_d;

    logic                    buf_valid;
    logic                    done;
    logic                    accept;
    logic                    clear;
    logic [NUM_OUT-1:0]      lane_done;

    // The held token keeps the mask it was accepted with.
    assign done   = buf_valid & (&lane_done);
    assign accept = in_valid & in_ready;
    assign clear  = accept | done;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_lane
        fanout_lane u_lane (
            .clk         (clk),
            .flush       (flush),
            .buf_valid_i (buf_valid),
            .tok_mask_i  (tok_mask_q[g]),
            .out_ready_i (out_ready[g]),
            .clear_i     (clear),
            .out_valid_o (out_valid[g]),
            .done_term_o (lane_done[g])
        );
        assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = buf_data_q;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept)          state_d = ST_HOLD;
            ST_HOLD:  if (done && !accept) state_d = ST_EMPTY;
            default:                       state_d = ST_EMPTY;
        endcase
    end

    // out_ready reaches in_ready through done, allowing back-to-back tokens.
    always_comb begin
        buf_valid = (state_q == ST_HOLD);
        in_ready  = ~flush & (~buf_valid | done);
    end

    always_comb begin
        buf_data_d  = buf_data_q;
        tok_mask_d  = tok_mask_q;
        tok_count_d = tok_count_q;
        if (accept) begin
            buf_data_d = in_data;
            tok_mask_d = cfg_en & cfg_sel;
        end
        if (done) begin
            tok_count_d = tok_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            buf_data_q  <= '0;
            tok_mask_q  <= '0;
            tok_count_q <= '0;
        end else begin
            buf_data_q  <= buf_data_d;
            tok_mask_q  <= tok_mask_d;
            tok_count_q <= tok_count_d;
        end
    end

    assign tok_count = tok_count_q;

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// Bench for fanout_fork_ctrl: directed scenarios plus randomized traffic
// checked against a token-level reference model.
module tb_fanout_fork_ctrl;
    import fanout_pkg::*;

    localparam int N  = FANOUT_NUM_OUT_DEFAULT;
    localparam int DW = FANOUT_DW_DEFAULT;

    logic              clk = 1'b0;
    logic              flush;
    logic [N-1:0]      cfg_en;
    logic [N-1:0]      cfg_sel;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   out_data;
    logic [N-1:0]      out_valid;
    logic [N-1:0]      out_ready;
    logic [15:0]       tok_count;

    always #5 clk = ~clk;

    fanout_fork_ctrl #(.NUM_OUT(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .flush     (flush),
        .cfg_en    (cfg_en),
        .cfg_sel   (cfg_sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tok_count (tok_count)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Token-level model: whether a token is held, its word, the lanes still
    // owed the token, and the number of completed tokens.
    bit            m_held;
    logic [DW-1:0] m_word;
    fanout_mask_t  m_owed;
    logic [15:0]   m_count;
    int            beats [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane(input int i);
        return out_data[i*DW +: DW];
    endfunction

    function automatic bit m_done();
        return m_held && ((m_owed & ~out_ready) == '0);
    endfunction

    task automatic check_model();
        fanout_mask_t exp_valid;
        bit           exp_ready;
        exp_valid = m_held ? m_owed : '0;
        exp_ready = !flush && (!m_held || m_done());
        chk("model_out_valid", 32'(out_valid), 32'(exp_valid));
        chk("model_in_ready", 32'(in_ready), 32'(exp_ready));
        chk("model_tok_count", 32'(tok_count), 32'(m_count));
        if (m_held) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("model_out_data[%0d]", i), 32'(lane(i)), 32'(m_word));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (out_valid[i] && out_ready[i]) beats[i]++;
        end
    endtask

    task automatic model_update();
        bit acc;
        bit dn;
        dn  = m_done();
        acc = in_valid && !flush && (!m_held || dn);
        if (flush) begin
            m_held  = 1'b0;
            m_owed  = '0;
            m_word  = '0;
            m_count = '0;
        end else begin
            if (dn) m_count = m_count + 16'd1;
            if (acc) begin
                m_held = 1'b1;
                m_word = in_data;
                m_owed = cfg_en & cfg_sel;
            end else if (dn) begin
                m_held = 1'b0;
                m_owed = '0;
            end else if (m_held) begin
                m_owed = m_owed & ~out_ready;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic do_flush();
        flush    = 1'b1;
        in_valid = 1'b0;
        step();
        flush    = 1'b0;
        for (int i = 0; i < N; i++) beats[i] = 0;
    endtask

    initial begin
        flush     = 1'b1;
        cfg_en    = '0;
        cfg_sel   = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = '0;
        for (int i = 0; i < N; i++) beats[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        m_held = 1'b0; m_owed = '0; m_word = '0; m_count = '0;
        flush  = 1'b0;

        // Reset state
        sample();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_tok_count", 32'(tok_count), 32'd0);
        advance();

        // Broadcast, all ready
        cfg_en = 7'h7F; cfg_sel = 7'h7F; out_ready = 7'h7F;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1;
            in_data  = 17'(k);
            sample();
            chk("bcast_in_ready", 32'(in_ready), 32'd1);
            if (k > 1) begin
                chk("bcast_out_valid", 32'(out_valid), 32'h7F);
                chk("bcast_lane0", 32'(lane(0)), 32'(k - 1));
            end
            advance();
        end
        in_valid = 1'b0;
        sample();
        chk("bcast_last_valid", 32'(out_valid), 32'h7F);
        chk("bcast_last_lane6", 32'(lane(6)), 32'd4);
        advance();
        sample();
        chk("bcast_tok_count", 32'(tok_count), 32'd4);
        advance();

        // Staggered consumers
        do_flush();
        cfg_en = 7'h07; cfg_sel = 7'h7F; out_ready = '0;
        in_valid = 1'b1; in_data = 17'h0_0055;
        step();
        in_valid = 1'b0;
        out_ready = 7'h01; step();
        out_ready = 7'h00; sample(); chk("stag_ready_t2", 32'(in_ready), 32'd0); advance();
        out_ready = 7'h02; sample(); chk("stag_ready_t3", 32'(in_ready), 32'd0); advance();
        out_ready = 7'h00; sample(); chk("stag_ready_t4", 32'(in_ready), 32'd0); advance();
        out_ready = 7'h04; sample(); chk("stag_ready_t5", 32'(in_ready), 32'd1); advance();
        out_ready = 7'h00;
        sample();
        chk("stag_tok_count", 32'(tok_count), 32'd1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("stag_beats[%0d]", i), 32'(beats[i]), (i < 3) ? 32'd1 : 32'd0);
        end
        advance();

        // Partial mask
        do_flush();
        cfg_en = 7'h7F; cfg_sel = 7'h05; out_ready = '0;
        in_valid = 1'b1; in_data = 17'h1_0F0F;
        step();
        in_valid = 1'b0;
        sample(); chk("part_out_valid", 32'(out_valid), 32'h05); advance();
        out_ready = 7'h7F;
        sample(); chk("part_in_ready", 32'(in_ready), 32'd1); advance();
        out_ready = '0;
        sample(); chk("part_tok_count", 32'(tok_count), 32'd1); advance();

        // Config change mid-token
        do_flush();
        cfg_en = 7'h7F; cfg_sel = 7'h03; out_ready = '0;
        in_valid = 1'b1; in_data = 17'h0_00A1;
        step();
        in_valid = 1'b0; out_ready = 7'h01;
        sample(); chk("cfg_out_valid_t1", 32'(out_valid), 32'h03); advance();
        cfg_sel = 7'h7C; in_valid = 1'b1; in_data = 17'h0_00A2; out_ready = '0;
        sample();
        chk("cfg_out_valid_t2", 32'(out_valid), 32'h02);
        chk("cfg_in_ready_t2", 32'(in_ready), 32'd0);
        advance();
        out_ready = 7'h02;
        sample(); chk("cfg_in_ready_t3", 32'(in_ready), 32'd1); advance();
        in_valid = 1'b0; out_ready = '0;
        sample();
        chk("cfg_next_mask", 32'(out_valid), 32'h7C);
        chk("cfg_tok_count", 32'(tok_count), 32'd1);
        advance();
        out_ready = 7'h7F; step();
        out_ready = '0; step();

        // Empty mask
        do_flush();
        cfg_en = '0; cfg_sel = 7'h7F; out_ready = '0;
        in_valid = 1'b1; in_data = 17'h1_ABCD;
        step();
        in_valid = 1'b0;
        sample();
        chk("empty_out_valid_t1", 32'(out_valid), 32'd0);
        chk("empty_in_ready_t1", 32'(in_ready), 32'd1);
        chk("empty_count_t1", 32'(tok_count), 32'd0);
        advance();
        sample();
        chk("empty_out_valid_t2", 32'(out_valid), 32'd0);
        chk("empty_count_t2", 32'(tok_count), 32'd1);
        advance();

        // Flush mid-HOLD
        do_flush();
        cfg_en = 7'h7F; cfg_sel = 7'h7F; out_ready = 7'h77;
        in_valid = 1'b1; in_data = 17'h1_2345;
        step();
        in_valid = 1'b0;
        sample(); chk("flush_out_valid_t1", 32'(out_valid), 32'h7F); advance();
        flush = 1'b1;
        sample();
        chk("flush_out_valid_t2", 32'(out_valid), 32'h08);
        chk("flush_in_ready_t2", 32'(in_ready), 32'd0);
        advance();
        flush = 1'b0; out_ready = 7'h7F; in_valid = 1'b1; in_data = 17'h0_BEEF;
        sample();
        chk("flush_out_valid_t3", 32'(out_valid), 32'd0);
        chk("flush_count_t3", 32'(tok_count), 32'd0);
        chk("flush_in_ready_t3", 32'(in_ready), 32'd1);
        advance();
        in_valid = 1'b0;
        sample();
        chk("flush_new_valid", 32'(out_valid), 32'h7F);
        chk("flush_new_data", 32'(lane(6)), 32'h0_BEEF);
        advance();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            cfg_en    = N'($urandom);
            cfg_sel   = N'($urandom | $urandom);
            out_ready = N'($urandom | $urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            flush     = ($urandom_range(0, 39) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 7'h7F;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
